// File: rtl/noc_pkg.sv
// noc_pkg: shared port indices, crossbar select encoding and allocator state type
package noc_pkg;
   localparam int P_N = 3;
   localparam int P_S = 2;
   localparam int P_E = 1;
   localparam int P_L = 0;
   localparam logic [2:0] XSEL_N    = 3'd0;
   localparam logic [2:0] XSEL_S    = 3'd1;
   localparam logic [2:0] XSEL_W    = 3'd2;
   localparam logic [2:0] XSEL_E    = 3'd3;
   localparam logic [2:0] XSEL_L    = 3'd4;
   localparam logic [2:0] XSEL_NONE = 3'd7;
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/credit_counter.sv
// credit_counter: downstream credit tracker with saturation and sticky overflow flag
module credit_counter #(
   parameter int CREDIT_DEPTH = 4,
   localparam int CNT_W = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dec_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             nz_o,
   output logic             ovf_o
);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDIT_DEPTH);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d, sat;
   // next count: a lone return at full is dropped and flagged
   always_comb begin
      sat   = inc_i & ~dec_i & (cnt_q == FULL);
      cnt_d = sat ? cnt_q : cnt_q - CNT_W'(dec_i) + CNT_W'(inc_i);
      ovf_d = ovf_q | sat;
   end
   // count and overflow registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= FULL;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end
   assign cnt_o = cnt_q;
   assign nz_o  = cnt_q != '0;
   assign ovf_o = ovf_q;
endmodule

// File: rtl/w_outport_alloc_ctrl.sv
// w_outport_alloc_ctrl: wormhole round-robin allocator and credit flow control for the west output
module w_outport_alloc_ctrl
   import noc_pkg::*;
#(
   parameter int CREDIT_DEPTH = 4,
   localparam int CNT_W = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       req_i,
   input  logic [3:0]       tail_i,
   input  logic             credit_return_i,
   output logic [3:0]       grant_o,
   output logic [3:0]       pop_o,
   output logic [2:0]       xbar_sel_o,
   output logic             flit_sent_o,
   output logic             rr_change_order_o,
   output logic [CNT_W-1:0] credit_cnt_o,
   output logic             busy_o,
   output logic             credit_err_o
);
   state_t     state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic [1:0] ptr_q, ptr_d, win;
   logic       nz, rel;

   // search ptr, ptr-1, ptr-2, ptr-3; later iterations are higher priority and overwrite
   function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [3:0] g;
      logic [1:0] idx;
      g = '0;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr - 2'(i);
         if (req[idx]) g = 4'b0001 << idx;
      end
      return g;
   endfunction

   credit_counter #(.CREDIT_DEPTH(CREDIT_DEPTH)) u_cc (
      .clk   (clk),
      .reset (reset),
      .dec_i (flit_sent_o),
      .inc_i (credit_return_i),
      .cnt_o (credit_cnt_o),
      .nz_o  (nz),
      .ovf_o (credit_err_o)
   );

   // state, grant and priority pointer registers; reset leaves N highest priority
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= 2'd3;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // lock onto a round-robin winner; release on a popped tail and demote the winner
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if (state_q == IDLE) begin
         if (|req_i) begin
            state_d = LOCKED;
            grant_d = rr_pick(req_i, ptr_q);
         end
      end else if (rel) begin
         state_d = IDLE;
         grant_d = '0;
         ptr_d   = win - 2'd1;
      end
   end

   // pops need a locked owner with a flit present and a free downstream slot
   always_comb begin
      pop_o             = (state_q == LOCKED && nz) ? grant_q & req_i : 4'b0000;
      rel               = |(pop_o & tail_i);
      win               = grant_q[3] ? 2'd3 : grant_q[2] ? 2'd2 : grant_q[1] ? 2'd1 : 2'd0;
      xbar_sel_o        = grant_q[P_N] ? XSEL_N : grant_q[P_S] ? XSEL_S :
                          grant_q[P_E] ? XSEL_E : grant_q[P_L] ? XSEL_L : XSEL_NONE;
      flit_sent_o       = |pop_o;
      rr_change_order_o = rel;
      busy_o            = state_q == LOCKED;
   end

   assign grant_o = grant_q;
endmodule

// File: doc/w_outport_alloc_ctrl.md
# w_outport_alloc_ctrl

Wormhole output-port allocator and flow controller for the router's west output. It takes head-flit requests from the N, S, E and L input buffers and picks one winner with rotating round-robin priority. It holds that grant until the winner's tail flit has left, and only lets flits go when the downstream west buffer has free credits. Outputs drive the crossbar select, the input-buffer pop strobes and the priority-rotation pulse.

## Interface
- CREDIT_DEPTH, 4: downstream west input-buffer depth in flits; legal range 1..15.
- CNT_W, $clog2(CREDIT_DEPTH+1): credit counter width; derived from CREDIT_DEPTH, never overridden.

- clk  in  1  router clock; the block's only clock.
- reset  in  1  synchronous, active-high.
- req_i  in  4  head/body flit valid and destined west; bit 3 N, 2 S, 1 E, 0 L.
- tail_i  in  4  flit currently presented on that input is a tail; qualified by req_i.
- credit_return_i  in  1  downstream freed one slot this cycle.
- grant_o  out  4  one-hot locked owner of the west output; registered.
- pop_o  out  4  dequeue strobe to the owning input buffer; combinational.
- xbar_sel_o  out  3  crossbar select: N=0, S=1, W=2 (never used), E=3, L=4, NONE=7.
- flit_sent_o  out  1  one flit crosses to west this cycle; equals |pop_o.
- rr_change_order_o  out  1  one-cycle pulse when a packet releases the port.
- credit_cnt_o  out  CNT_W  credits currently available.
- busy_o  out  1  port locked (state LOCKED).
- credit_err_o  out  1  sticky; credit returned while the count is already CREDIT_DEPTH.

## Operation
- FSM states:
  - IDLE: if req_i != 0, the winner is chosen by round-robin, grant_o is loaded and the FSM goes to LOCKED. Otherwise it stays in IDLE.
  - LOCKED: the grant is held until a tail flit is sent.
- Round-robin: a 2-bit pointer ptr gives the highest-priority index. The search order is ptr, ptr-1, ptr-2, ptr-3 (mod 4) over req_i bits.
  - After winner w releases, ptr <= (w-1) mod 4, so the winner becomes lowest priority.
  - The ptr update coincides with the rr_change_order_o pulse.
- Send condition in LOCKED: pop_o[g] = grant_o[g] & req_i[g] & (credit_cnt_o != 0).
- Release: a send with tail_i[g]=1 pulses rr_change_order_o that cycle, updates ptr, clears grant_o and returns to IDLE on the next edge.
- While locked, a bubble (req_i[g]=0) keeps the lock. Requests from other inputs are ignored until release.
- Credits, per cycle: count <= count - send + return.
  - Send and return in the same cycle leave the count unchanged.
  - A return while count == CREDIT_DEPTH with no send in that cycle saturates the count and sets credit_err_o.
- xbar_sel_o is encoded from grant_o; it is NONE when grant_o == 0.
- Reset values: state IDLE, grant_o 0, pop_o 0, xbar_sel_o 7, flit_sent_o 0, rr_change_order_o 0, busy_o 0, credit_cnt_o CREDIT_DEPTH, credit_err_o 0, ptr 3 (N highest).
- Reset mid-packet drops the lock immediately with no release pulse. Upstream buffers are reset together with this block.

## Timing
- Request seen in IDLE at edge t gives grant_o valid after t. The first pop can happen in the cycle following t.
- Throughput is 1 flit/cycle while credits are available and req_i[g] stays high.
- There is exactly one idle cycle between a tail pop and the next grant.
- A single-flit packet (req and tail together, in the cycle after the grant) is popped and released in that same cycle.
- A credit returned at edge t can be used by a pop in the cycle after t. There is no bypass from credit_return_i to pop_o.

## Structure
- Shared package noc_pkg holds:
  - port index constants: N=3, S=2, E=1, L=0;
  - the xbar select encoding: XSEL_N/S/W/E/L/NONE;
  - the state typedef: enum {IDLE, LOCKED}.
- Sub-module credit_counter (parameter CREDIT_DEPTH): inputs for decrement and increment; outputs for count, nonzero flag and sticky overflow.
- The round-robin pick is a combinational function inside the top module.

## Test plan
- Reset, then req_i=4'b1111 with all tails high:
  - grants go N, S, E, L, N, each followed by one idle cycle;
  - rr_change_order_o pulses 5 times.
- Grant to S for a 5-flit packet while N also requests:
  - N is not granted until S's tail pops;
  - xbar_sel_o=1 throughout the lock.
- CREDIT_DEPTH=4, 6-flit packet from L, no credit returns:
  - 4 pops, then a stall with credit_cnt_o=0 and busy_o=1;
  - one credit_return_i gives exactly one more pop.
- Bubble: E is granted and req_i[1] drops for 3 cycles mid-packet:
  - no pop and the grant holds;
  - popping resumes when req_i[1] returns.
- Simultaneous credit_return_i and pop at count 2: count stays 2. A return at count 4 with no pop: count stays 4 and credit_err_o=1.
- reset asserted mid-packet: the next cycle shows IDLE, grant_o=0, credit_cnt_o=CREDIT_DEPTH and ptr back to N.
